// File: rtl/obi_resp_pkg.sv
// Shared types and integrity helpers for the OBI responder.
// Even parity per byte; the response check vector is {err, byte parities}.
package obi_resp_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    // Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] byte_par4(input logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    function automatic logic [4:0] rchk_calc(input resp_t r);
        return {r.err, byte_par4(r.rdata)};
    endfunction

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-latency response pipeline: a response entering in cycle N leaves
// the last stage in cycle N+RESP_LAT. Reset empties every stage.
module obi_resp_delay_line
    import obi_resp_pkg::*;
#(
    parameter int unsigned RESP_LAT = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  in_valid_i,
    input  resp_t in_resp_i,
    output logic  out_valid_o,
    output resp_t out_resp_o
);

    logic  [RESP_LAT-1:0] valid_d, valid_q;
    resp_t [RESP_LAT-1:0] resp_d, resp_q;

    always_comb begin
        valid_d    = valid_q;
        resp_d     = resp_q;
        valid_d[0] = in_valid_i;
        resp_d[0]  = in_resp_i;
        for (int i = 1; i < int'(RESP_LAT); i++) begin
            valid_d[i] = valid_q[i-1];
            resp_d[i]  = resp_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            resp_q  <= '0;
        end else begin
            valid_q <= valid_d;
            resp_q  <= resp_d;
        end
    end

    assign out_valid_o = valid_q[RESP_LAT-1];
    assign out_resp_o  = resp_q[RESP_LAT-1];

endmodule

// File: rtl/obi_integrity_responder.sv
// Memory-side OBI responder with integrity generation/checking for one core port.
// Optional random grant stalls are enabled by defining OBI_RESP_STALL_EN.
module obi_integrity_responder
    import obi_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned RESP_LAT  = 1,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic                         reqpar_i,
    input  logic [31:0]                  addr_i,
    input  logic [12:0]                  achk_i,
    input  logic [3:0]                   be_i,
    input  logic                         we_i,
    input  logic [31:0]                  wdata_i,
    output logic                         gnt_o,
    output logic                         gntpar_o,
    output logic                         rvalid_o,
    output logic                         rvalidpar_o,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    output logic [4:0]                   rchk_o,
    output logic                         integrity_err_o,
    input  logic                         load_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_idx_i,
    input  logic [31:0]                  load_data_i
);

    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN    = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTST);

    // Handshake: a request transfers in any cycle with req_i && gnt_o; its
    // response is shown for exactly one cycle RESP_LAT cycles later, with no
    // ready/backpressure on the response side.

    logic stall;
`ifdef OBI_RESP_STALL_EN
    logic [15:0] lfsr_d, lfsr_q;

    always_comb lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    logic [32:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // 33-bit difference: addresses below the base wrap into bit 32 and fall out of range.
    assign offset   = {1'b0, addr_i} - {1'b0, ADDR_BASE};
    assign in_range = (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];

    logic  out_valid;
    resp_t out_resp;
    logic  gnt;
    logic [3:0] cnt_d, cnt_q;

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign gnt = req_i && !stall && ((cnt_q < MAX_CNT) || out_valid);

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !out_valid)      cnt_d = cnt_q + 4'd1;
        else if (!gnt && out_valid) cnt_d = cnt_q - 4'd1;
    end

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rd_word;
    logic        bus_wr;

    assign bus_wr  = gnt && we_i && in_range;
    assign rd_word = (load_en_i && (load_idx_i == idx)) ? load_data_i : mem_q[idx];

    // Backdoor load is written last so it wins over a same-index bus write.
    always_ff @(posedge clk_i) begin
        if (bus_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (load_en_i) mem_q[load_idx_i] <= load_data_i;
    end

    resp_t resp_in;

    always_comb begin
        resp_in = '0;
        if (gnt) begin
            if (!in_range)  resp_in.err   = 1'b1;
            else if (!we_i) resp_in.rdata = rd_word;
        end
    end

    obi_resp_delay_line #(
        .RESP_LAT (RESP_LAT)
    ) u_delay (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (gnt),
        .in_resp_i   (resp_in),
        .out_valid_o (out_valid),
        .out_resp_o  (out_resp)
    );

    logic int_err_d, int_err_q;

    always_comb begin
        int_err_d = int_err_q;
        if (reqpar_i == req_i)                                     int_err_d = 1'b1;
        if (gnt && (achk_i[3:0] != byte_par4(addr_i)))             int_err_d = 1'b1;
        if (gnt && we_i && (achk_i[10:7] != byte_par4(wdata_i)))   int_err_d = 1'b1;
    end

    logic unused_achk;
    assign unused_achk = ^{achk_i[12:11], achk_i[6:4]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            int_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            int_err_q <= int_err_d;
        end
    end

    resp_t resp_vis;
    assign resp_vis = out_valid ? out_resp : '0;

    assign gnt_o           = gnt;
    assign gntpar_o        = ~gnt;
    assign rvalid_o        = out_valid;
    assign rvalidpar_o     = ~out_valid;
    assign rdata_o         = resp_vis.rdata;
    assign err_o           = resp_vis.err;
    assign rchk_o          = rchk_calc(resp_vis);
    assign integrity_err_o = int_err_q;

endmodule

// File: tb/tb_obi_integrity_responder.sv
// Bench for obi_integrity_responder: instance A (latency 1, defaults) for
// directed vectors and integrity checks, instance B (latency 3) for timing and random traffic.
module tb_obi_integrity_responder;

    localparam logic [31:0] B_BASE  = 32'h0000_1000;
    localparam int          B_WORDS = 16;
    localparam int          B_LAT   = 3;
    localparam int          B_MAX   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        req;
        logic        reqpar;
        logic [31:0] addr;
        logic [12:0] achk;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        load_en;
        logic [9:0]  load_idx;
        logic [31:0] load_data;
    } drv_t;

    typedef struct packed {
        logic        gnt;
        logic        gntpar;
        logic        rvalid;
        logic        rvalidpar;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rchk;
        logic        ierr;
    } mon_t;

    drv_t a_in, b_in;
    mon_t a_mon, b_mon;

    logic a_gnt, a_gntpar, a_rvalid, a_rvalidpar, a_err, a_ierr;
    logic b_gnt, b_gntpar, b_rvalid, b_rvalidpar, b_err, b_ierr;
    logic [31:0] a_rdata, b_rdata;
    logic [4:0]  a_rchk, b_rchk;

    assign a_mon = {a_gnt, a_gntpar, a_rvalid, a_rvalidpar, a_rdata, a_err, a_rchk, a_ierr};
    assign b_mon = {b_gnt, b_gntpar, b_rvalid, b_rvalidpar, b_rdata, b_err, b_rchk, b_ierr};

    obi_integrity_responder u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(a_in.req), .reqpar_i(a_in.reqpar), .addr_i(a_in.addr), .achk_i(a_in.achk),
        .be_i(a_in.be), .we_i(a_in.we), .wdata_i(a_in.wdata),
        .gnt_o(a_gnt), .gntpar_o(a_gntpar), .rvalid_o(a_rvalid), .rvalidpar_o(a_rvalidpar),
        .rdata_o(a_rdata), .err_o(a_err), .rchk_o(a_rchk), .integrity_err_o(a_ierr),
        .load_en_i(a_in.load_en), .load_idx_i(a_in.load_idx), .load_data_i(a_in.load_data)
    );

    obi_integrity_responder #(
        .MEM_WORDS(B_WORDS), .ADDR_BASE(B_BASE), .RESP_LAT(B_LAT), .MAX_OUTST(B_MAX)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(b_in.req), .reqpar_i(b_in.reqpar), .addr_i(b_in.addr), .achk_i(b_in.achk),
        .be_i(b_in.be), .we_i(b_in.we), .wdata_i(b_in.wdata),
        .gnt_o(b_gnt), .gntpar_o(b_gntpar), .rvalid_o(b_rvalid), .rvalidpar_o(b_rvalidpar),
        .rdata_o(b_rdata), .err_o(b_err), .rchk_o(b_rchk), .integrity_err_o(b_ierr),
        .load_en_i(b_in.load_en), .load_idx_i(b_in.load_idx[3:0]), .load_data_i(b_in.load_data)
    );

    // ---------------- helpers ----------------
    function automatic logic [3:0] ref_par4(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = (($countones((d >> (8 * i)) & 32'hff) % 2) == 1);
        return p;
    endfunction

    function automatic logic [4:0] ref_rchk(input logic [31:0] d, input logic e);
        return {e, ref_par4(d)};
    endfunction

    function automatic drv_t idle();
        drv_t d = '0;
        d.reqpar = 1'b1;
        return d;
    endfunction

    function automatic drv_t bus(input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        drv_t d = idle();
        d.req = 1'b1; d.reqpar = 1'b0; d.we = we; d.addr = addr; d.be = be; d.wdata = wdata;
        d.achk[3:0]  = ref_par4(addr);
        d.achk[10:7] = ref_par4(wdata);
        return d;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input mon_t m, input logic rv,
                            input logic [31:0] rd, input logic er, input logic [4:0] rc);
        chk({tag, ".rvalid"},    32'(m.rvalid),    32'(rv));
        chk({tag, ".rvalidpar"}, 32'(m.rvalidpar), 32'(!rv));
        chk({tag, ".rdata"},     m.rdata,          rv ? rd : 32'h0);
        chk({tag, ".err"},       32'(m.err),       32'(rv & er));
        chk({tag, ".rchk"},      32'(m.rchk),      rv ? 32'(rc) : 32'h0);
    endtask

    task automatic chk_gnt(input string tag, input mon_t m, input logic g);
        chk({tag, ".gnt"},    32'(m.gnt),    32'(g));
        chk({tag, ".gntpar"}, 32'(m.gntpar), 32'(!g));
    endtask

    task automatic pulse_reset();
        nxt();
        a_in = idle();
        b_in = idle();
        rst_n = 1'b0;
        #1;
        chk("reset.a_ierr_clear", 32'(a_ierr), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model of instance B ----------------
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_b[B_WORDS];

    task automatic model_step(input drv_t d);
        int          pend;
        logic        exp_g;
        logic        ok;
        int          wi;
        logic [31:0] rd;
        exp_t        e;
        pend = 0;
        foreach (exp_q[i]) if (exp_q[i].due > cyc) pend++;
        exp_g = d.req && (pend < B_MAX);
        chk_gnt("b_rnd", b_mon, exp_g);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk_resp("b_rnd", b_mon, 1'b1, e.rdata, e.err, ref_rchk(e.rdata, e.err));
        end else begin
            chk_resp("b_rnd", b_mon, 1'b0, 32'h0, 1'b0, 5'h0);
        end
        if (exp_g) begin
            ok = (d.addr >= B_BASE) && (d.addr < B_BASE + 4 * B_WORDS);
            wi = int'((d.addr - B_BASE) >> 2);
            if (!ok) begin
                exp_q.push_back('{cyc + B_LAT, 32'h0, 1'b1});
            end else if (d.we) begin
                for (int b = 0; b < 4; b++) if (d.be[b]) mem_b[wi][8*b +: 8] = d.wdata[8*b +: 8];
                exp_q.push_back('{cyc + B_LAT, 32'h0, 1'b0});
            end else begin
                rd = (d.load_en && int'(d.load_idx) == wi) ? d.load_data : mem_b[wi];
                exp_q.push_back('{cyc + B_LAT, rd, 1'b0});
            end
        end
        if (d.load_en) mem_b[d.load_idx[3:0]] = d.load_data;
    endtask

    // ---------------- directed vector table for instance A ----------------
    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        ld;
        logic [9:0]  ld_idx;
        logic [31:0] ld_data;
        logic        x_gnt;
        logic [31:0] x_rdata;
        logic        x_err;
        logic [4:0]  x_rchk;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    initial begin
        drv_t d;
        int   seen;
        int   r;

        vt[0]  = '{1, 0, 32'h0000_0000, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h01c0_0093, 0, 5'b01000};
        vt[1]  = '{1, 1, 32'h0000_0024, 4'h1, 32'h0000_00cd, 0, 10'd0, 32'h0,         1, 32'h0,         0, 5'b00000};
        vt[2]  = '{1, 0, 32'h0000_0024, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h0000_00cd, 0, 5'b00001};
        vt[3]  = '{1, 1, 32'h0000_0028, 4'h4, 32'h0077_0000, 0, 10'd0, 32'h0,         1, 32'h0,         0, 5'b00000};
        vt[4]  = '{1, 0, 32'h0000_002a, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'ha577_a5a5, 0, 5'b00000};
        vt[5]  = '{1, 0, 32'h0000_1000, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h0,         1, 5'b10000};
        vt[6]  = '{1, 1, 32'h0000_1000, 4'hf, 32'hffff_ffff, 0, 10'd0, 32'h0,         1, 32'h0,         1, 5'b10000};
        vt[7]  = '{1, 0, 32'h0000_0000, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h01c0_0093, 0, 5'b01000};
        vt[8]  = '{1, 0, 32'h0000_0014, 4'h0, 32'h0,         1, 10'd5, 32'h1234_5678, 1, 32'h1234_5678, 0, 5'b00100};
        vt[9]  = '{1, 1, 32'h0000_0014, 4'hf, 32'hdead_beef, 1, 10'd5, 32'h0f0f_0f0f, 1, 32'h0,         0, 5'b00000};
        vt[10] = '{1, 0, 32'h0000_0014, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h0f0f_0f0f, 0, 5'b00000};
        vt[11] = '{0, 0, 32'h0000_0000, 4'h0, 32'h0,         0, 10'd0, 32'h0,         0, 32'h0,         0, 5'b00000};
        vt[12] = '{1, 0, 32'h0000_0ffc, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h8000_0001, 0, 5'b01001};
        vt[13] = '{1, 0, 32'hffff_fffc, 4'h0, 32'h0,         0, 10'd0, 32'h0,         1, 32'h0,         1, 5'b10000};

        a_in  = idle();
        b_in  = idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_gnt("rst_a", a_mon, 1'b0);
        chk_resp("rst_a", a_mon, 1'b0, 32'h0, 1'b0, 5'h0);
        chk("rst_a.ierr", 32'(a_ierr), 0);
        chk_gnt("rst_b", b_mon, 1'b0);
        chk_resp("rst_b", b_mon, 1'b0, 32'h0, 1'b0, 5'h0);
        chk("rst_b.ierr", 32'(b_ierr), 0);
        rst_n = 1'b1;

        // Preload A through the backdoor.
        for (int k = 0; k < 5; k++) begin
            nxt();
            a_in = idle();
            a_in.load_en = 1'b1;
            case (k)
                0: begin a_in.load_idx = 10'd0;    a_in.load_data = 32'h01c0_0093; end
                1: begin a_in.load_idx = 10'd5;    a_in.load_data = 32'h0000_0000; end
                2: begin a_in.load_idx = 10'd9;    a_in.load_data = 32'h0000_00ff; end
                3: begin a_in.load_idx = 10'd10;   a_in.load_data = 32'ha5a5_a5a5; end
                default: begin a_in.load_idx = 10'd1023; a_in.load_data = 32'h8000_0001; end
            endcase
        end

        for (int k = 0; k < NV; k++) begin
            nxt();
            a_in = vt[k].req ? bus(vt[k].we, vt[k].addr, vt[k].be, vt[k].wdata) : idle();
            a_in.load_en   = vt[k].ld;
            a_in.load_idx  = vt[k].ld_idx;
            a_in.load_data = vt[k].ld_data;
            mid();
            chk_gnt($sformatf("vec%0d", k), a_mon, vt[k].x_gnt);
            nxt();
            a_in = idle();
            mid();
            chk_resp($sformatf("vec%0d", k), a_mon, vt[k].x_gnt, vt[k].x_rdata, vt[k].x_err, vt[k].x_rchk);
        end

        // Integrity: bad reqpar is sticky until reset.
        chk("int.clean_after_vectors", 32'(a_ierr), 0);
        nxt(); a_in = idle(); a_in.reqpar = 1'b0; mid();
        chk("int.reqpar_not_yet", 32'(a_ierr), 0);
        nxt(); a_in = idle(); mid();
        chk("int.reqpar_set", 32'(a_ierr), 1);
        repeat (3) nxt();
        mid();
        chk("int.reqpar_held", 32'(a_ierr), 1);
        pulse_reset();

        // Ignored achk bits and ungranted cycles leave the flag clear.
        nxt(); a_in = idle(); a_in.achk = 13'h1fff; mid();
        nxt(); a_in = bus(1'b0, 32'h0, 4'h0, 32'h0); a_in.achk[4] ^= 1'b1; a_in.achk[12] ^= 1'b1; mid();
        nxt(); a_in = idle(); mid();
        chk("int.ignored_bits", 32'(a_ierr), 0);
        nxt(); a_in = bus(1'b0, 32'h0, 4'h0, 32'h0); a_in.achk[0] ^= 1'b1; mid();
        nxt(); a_in = idle(); mid();
        chk("int.bad_addr_achk", 32'(a_ierr), 1);
        pulse_reset();
        nxt(); a_in = bus(1'b1, 32'h40, 4'hf, 32'h0000_0001); a_in.achk[7] ^= 1'b1; mid();
        nxt(); a_in = idle(); mid();
        chk("int.bad_wdata_achk", 32'(a_ierr), 1);
        pulse_reset();

        // Preload B fully and mirror it in the model.
        for (int k = 0; k < B_WORDS; k++) begin
            nxt();
            b_in = idle();
            b_in.load_en   = 1'b1;
            b_in.load_idx  = 10'(k);
            b_in.load_data = $urandom;
            mem_b[k] = b_in.load_data;
        end

        // B: held reads against MAX_OUTST=2 with latency 3.
        for (int c = 0; c < 9; c++) begin
            logic [8:0] xg;
            logic [8:0] xr;
            xg = 9'b000011011;
            xr = 9'b011011000;
            nxt();
            b_in = (c < 5) ? bus(1'b0, B_BASE + 32'h1c, 4'h0, 32'h0) : idle();
            mid();
            chk_gnt($sformatf("b_outst.c%0d", c), b_mon, xg[c]);
            chk_resp($sformatf("b_outst.c%0d", c), b_mon, xr[c], mem_b[7], 1'b0, ref_rchk(mem_b[7], 1'b0));
        end

        // B: reset with two responses in flight.
        nxt(); b_in = bus(1'b0, B_BASE + 32'h8, 4'h0, 32'h0); mid();
        nxt(); b_in = bus(1'b0, B_BASE + 32'hc, 4'h0, 32'h0); mid();
        nxt(); b_in = idle(); mid();
        nxt(); mid();
        chk("b_rst.rvalid_before", 32'(b_rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("b_rst.rvalid_cleared", 32'(b_rvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            nxt(); b_in = idle(); mid();
            if (b_rvalid) seen++;
        end
        chk("b_rst.no_stale_rvalid", 32'(seen), 0);
        for (int c = 0; c < 6; c++) begin
            logic [5:0] xg;
            logic [5:0] xr;
            xg = 6'b000011;
            xr = 6'b011000;
            nxt();
            b_in = (c < 3) ? bus(1'b0, B_BASE + 32'h4, 4'h0, 32'h0) : idle();
            mid();
            chk_gnt($sformatf("b_after_rst.c%0d", c), b_mon, xg[c]);
            chk_resp($sformatf("b_after_rst.c%0d", c), b_mon, xr[c], mem_b[1], 1'b0, ref_rchk(mem_b[1], 1'b0));
        end

        // B: random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            nxt();
            d = idle();
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 9);
                if (r == 0)      d.addr = B_BASE - 32'($urandom_range(1, 8));
                else if (r == 1) d.addr = B_BASE + 32'(4 * B_WORDS) + 32'($urandom_range(0, 7));
                else             d.addr = B_BASE + 32'($urandom_range(0, 4 * B_WORDS - 1));
                d = bus(1'($urandom_range(0, 1)), d.addr, 4'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                d.load_en   = 1'b1;
                d.load_idx  = 10'($urandom_range(0, B_WORDS - 1));
                d.load_data = $urandom;
            end
            b_in = d;
            mid();
            model_step(d);
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            nxt(); b_in = idle(); mid();
            model_step(b_in);
        end
        chk("b_drain.queue_empty", 32'(exp_q.size()), 0);
        chk("b_rnd.ierr_clean", 32'(b_ierr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
